// File: rtl/burst_coalescer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : burst_coalescer_pkg
// Purpose  : Shared constants for the burst coalescer: FSM state encoding,
//            AXI length width, default no-cross boundary and the beat
//            alignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package burst_coalescer_pkg;

  localparam int AXI_LEN_WIDTH        = 8;
  localparam int DEFAULT_BOUNDARY_LOG = 12;
  localparam int MAX_ADDR_WIDTH       = 64;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  // Clears the low lsb_bits of an address so it points at the start of a beat.
  function automatic logic [MAX_ADDR_WIDTH-1:0] align_addr(
    input logic [MAX_ADDR_WIDTH-1:0] addr,
    input int unsigned               lsb_bits
  );
    logic [MAX_ADDR_WIDTH-1:0] mask;
    mask = ~((MAX_ADDR_WIDTH'(1) << lsb_bits) - MAX_ADDR_WIDTH'(1));
    return addr & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/burst_coalescer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin pick of the first requesting channel at or after
//            the pointer, wrapping past the last channel.
// Ports    : req        - per-channel request
//            ptr        - channel with highest priority this cycle
//            grant      - one-hot grant (all zero when nothing requests)
//            grant_idx  - index of the granted channel
//            grant_valid- at least one channel requests
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NumChannels = 2,
  parameter int IdxWidth    = 1
) (
  input  logic [NumChannels-1:0] req,
  input  logic [IdxWidth-1:0]    ptr,
  output logic [NumChannels-1:0] grant,
  output logic [IdxWidth-1:0]    grant_idx,
  output logic                   grant_valid
);

  // Rotating the doubled request vector right by ptr puts the pointer
  // channel at bit 0, so a plain lowest-bit search gives round-robin order.
  logic [2*NumChannels-1:0] w_req_dbl;
  logic [NumChannels-1:0]   w_req_rot;

  assign w_req_dbl = {req, req} >> ptr;
  assign w_req_rot = w_req_dbl[NumChannels-1:0];

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Descending scan: the smallest offset is assigned last and wins.
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        grant_idx   = IdxWidth'((int'(ptr) + i) % NumChannels);
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int j = 0; j < NumChannels; j++) begin
      grant[j] = grant_valid && (grant_idx == IdxWidth'(j));
    end
  end

endmodule
`default_nettype wire

// File: rtl/burst_coalescer.sv
`default_nettype none
// ============================================================================
// Module   : burst_coalescer
// Purpose  : Round-robin merges per-channel beat addresses into AXI INCR
//            bursts tagged with the channel as AXI ID. A burst closes on a
//            non-contiguous address, at max_burst_len, before crossing the
//            2**BoundaryLog byte boundary, or after max_wait_time idle cycles.
//            Each burst is pushed atomically to the address relay and to the
//            two {id,len} bookkeeping FIFOs.
// Ports    : clk, rst_n            - clock, async active-low reset
//            max_wait_time         - idle cycles tolerated inside a burst
//            max_burst_len         - largest LEN (beats-1)
//            addr_dout/addr_empty_n/addr_read - per-channel address FIFOs
//            burst_addr_*          - {id,len,addr} to AW/AR relay
//            burst_len_0_*/1_*     - {id,len} to W-last / B-response trackers
//            stat_*                - counters, only with
//                                    BURST_COALESCER_STATS_EN defined
// Revision : 1.0 - initial release
// ============================================================================
module burst_coalescer
  import burst_coalescer_pkg::*;
#(
  parameter int AddrWidth         = 64,
  parameter int DataWidthBytesLog = 6,
  parameter int WaitTimeWidth     = 4,
  parameter int BurstLenWidth     = AXI_LEN_WIDTH,
  parameter int NumChannels       = 2,
  parameter int ChanIdWidth       = 1,
  parameter int BoundaryLog       = DEFAULT_BOUNDARY_LOG
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [WaitTimeWidth-1:0]                   max_wait_time,
  input  logic [BurstLenWidth-1:0]                   max_burst_len,
  input  logic [NumChannels*AddrWidth-1:0]           addr_dout,
  input  logic [NumChannels-1:0]                     addr_empty_n,
  output logic [NumChannels-1:0]                     addr_read,
  output logic [ChanIdWidth+BurstLenWidth+AddrWidth-1:0] burst_addr_din,
  input  logic                                       burst_addr_full_n,
  output logic                                       burst_addr_write,
  output logic [ChanIdWidth+BurstLenWidth-1:0]       burst_len_0_din,
  input  logic                                       burst_len_0_full_n,
  output logic                                       burst_len_0_write,
  output logic [ChanIdWidth+BurstLenWidth-1:0]       burst_len_1_din,
  input  logic                                       burst_len_1_full_n,
  output logic                                       burst_len_1_write
`ifdef BURST_COALESCER_STATS_EN
  ,
  output logic [31:0]                                stat_bursts,
  output logic [31:0]                                stat_beats,
  output logic [31:0]                                stat_timeouts
`endif
);

  function automatic logic [AddrWidth-1:0] beat_align(input logic [AddrWidth-1:0] a);
    return AddrWidth'(align_addr(MAX_ADDR_WIDTH'(a), DataWidthBytesLog));
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]               r_state;
  logic [ChanIdWidth-1:0]   r_rr_ptr;
  logic [ChanIdWidth-1:0]   r_cur_id;
  logic [AddrWidth-1:0]     r_base;
  logic [BurstLenWidth-1:0] r_len;
  logic [WaitTimeWidth-1:0] r_wait_cnt;

  // --------------------------------------------------------------------------
  // Per-channel address unpacking
  // --------------------------------------------------------------------------
  logic [AddrWidth-1:0] w_ch_addr [NumChannels];

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
    assign w_ch_addr[gi] = addr_dout[gi*AddrWidth +: AddrWidth];
  end

  // --------------------------------------------------------------------------
  // Arbitration (only consulted in IDLE)
  // --------------------------------------------------------------------------
  logic [NumChannels-1:0] w_grant;
  logic [ChanIdWidth-1:0] w_grant_idx;
  logic                   w_grant_valid;

  rr_arbiter #(
    .NumChannels (NumChannels),
    .IdxWidth    (ChanIdWidth)
  ) u_rr_arbiter (
    .req         (addr_empty_n),
    .ptr         (r_rr_ptr),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  // --------------------------------------------------------------------------
  // Datapath selects
  // --------------------------------------------------------------------------
  logic [AddrWidth-1:0] w_cur_addr;
  logic                 w_cur_valid;
  logic [AddrWidth-1:0] w_grant_addr;

  always_comb begin
    w_cur_addr   = '0;
    w_cur_valid  = 1'b0;
    w_grant_addr = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (r_cur_id == ChanIdWidth'(i)) begin
        w_cur_addr  = w_ch_addr[i];
        w_cur_valid = addr_empty_n[i];
      end
      if (w_grant[i]) begin
        w_grant_addr = w_ch_addr[i];
      end
    end
  end

  // len is widened before the +1 so a full-range LEN cannot wrap the offset;
  // the sum itself wraps modulo 2**AddrWidth.
  logic [AddrWidth-1:0] w_next_addr;
  assign w_next_addr = r_base + ((AddrWidth'(r_len) + AddrWidth'(1)) << DataWidthBytesLog);

  // Burst must close before looking at input: length limit reached, or the
  // next beat would start a new boundary region. The >= also closes cleanly
  // if the limit is lowered while a burst is open, so len never exceeds it.
  logic w_close_limit;
  assign w_close_limit = (r_len >= max_burst_len) ||
                         (w_next_addr[BoundaryLog-1:0] == '0);

  logic w_in_accum;
  logic w_accept;
  logic w_timeout;
  logic w_push;

  assign w_in_accum = (r_state == S_ACCUM);
  assign w_accept   = w_in_accum && !w_close_limit && w_cur_valid &&
                      (beat_align(w_cur_addr) == w_next_addr);
  assign w_timeout  = w_in_accum && !w_close_limit && !w_cur_valid &&
                      (r_wait_cnt == max_wait_time);
  assign w_push     = (r_state == S_EMIT) && burst_addr_full_n &&
                      burst_len_0_full_n && burst_len_1_full_n;

  logic [ChanIdWidth-1:0] w_next_ptr;
  assign w_next_ptr = (r_cur_id == ChanIdWidth'(NumChannels - 1)) ? '0
                                                                  : r_cur_id + ChanIdWidth'(1);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_cur_id   <= '0;
      r_base     <= '0;
      r_len      <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_base     <= beat_align(w_grant_addr);
            r_cur_id   <= w_grant_idx;
            r_len      <= '0;
            r_wait_cnt <= '0;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_close_limit) begin
            r_state <= S_EMIT;
          end else if (w_accept) begin
            // Acceptance takes precedence over a timeout in the same cycle.
            r_len      <= r_len + BurstLenWidth'(1);
            r_wait_cnt <= '0;
          end else if (w_cur_valid) begin
            // Non-contiguous word stays in its FIFO for the next burst.
            r_state <= S_EMIT;
          end else if (w_timeout) begin
            r_state <= S_EMIT;
          end else begin
            r_wait_cnt <= r_wait_cnt + WaitTimeWidth'(1);
          end
        end
        S_EMIT: begin
          if (w_push) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  logic [NumChannels-1:0] w_read;

  always_comb begin
    w_read = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if ((r_state == S_IDLE) && w_grant[i]) begin
        w_read[i] = 1'b1;
      end
      if (w_accept && (r_cur_id == ChanIdWidth'(i))) begin
        w_read[i] = 1'b1;
      end
    end
  end

  // IDLE pops combinationally from addr_empty_n, so gate with rst_n to keep
  // the FIFOs untouched while reset is held.
  assign addr_read         = w_read & {NumChannels{rst_n}};

  assign burst_addr_din    = {r_cur_id, r_len, r_base};
  assign burst_len_0_din   = {r_cur_id, r_len};
  assign burst_len_1_din   = {r_cur_id, r_len};
  assign burst_addr_write  = w_push;
  assign burst_len_0_write = w_push;
  assign burst_len_1_write = w_push;

`ifdef BURST_COALESCER_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics (free-running, wrapping)
  // --------------------------------------------------------------------------
  logic [31:0] r_stat_bursts;
  logic [31:0] r_stat_beats;
  logic [31:0] r_stat_timeouts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_bursts   <= '0;
      r_stat_beats    <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (w_push) begin
        r_stat_bursts <= r_stat_bursts + 32'd1;
        r_stat_beats  <= r_stat_beats + 32'(r_len) + 32'd1;
      end
      if (w_timeout) begin
        r_stat_timeouts <= r_stat_timeouts + 32'd1;
      end
    end
  end

  assign stat_bursts   = r_stat_bursts;
  assign stat_beats    = r_stat_beats;
  assign stat_timeouts = r_stat_timeouts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_burst_coalescer.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_coalescer
// Purpose  : Scoreboard bench for burst_coalescer. Channel FIFOs are modelled
//            as queues; each batch is loaded while the DUT is idle, and a
//            burst-level reference model derives the expected pushes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_coalescer;

  localparam int AW  = 64;
  localparam int NCH = 2;
  localparam int IDW = 1;
  localparam int LW  = 8;
  localparam int WW  = 4;
  localparam int BW  = IDW + LW + AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [WW-1:0]      max_wait_time = '0;
  logic [LW-1:0]      max_burst_len = '0;
  logic [NCH*AW-1:0]  addr_dout     = '0;
  logic [NCH-1:0]     addr_empty_n  = '0;
  logic [NCH-1:0]     addr_read;
  logic [BW-1:0]      burst_addr_din;
  logic               burst_addr_full_n  = 1'b1;
  logic               burst_addr_write;
  logic [IDW+LW-1:0]  burst_len_0_din;
  logic               burst_len_0_full_n = 1'b1;
  logic               burst_len_0_write;
  logic [IDW+LW-1:0]  burst_len_1_din;
  logic               burst_len_1_full_n = 1'b1;
  logic               burst_len_1_write;
`ifdef BURST_COALESCER_STATS_EN
  logic [31:0] stat_bursts, stat_beats, stat_timeouts;
`endif

  burst_coalescer #(
    .AddrWidth(AW), .DataWidthBytesLog(6), .WaitTimeWidth(WW), .BurstLenWidth(LW),
    .NumChannels(NCH), .ChanIdWidth(IDW), .BoundaryLog(12)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .max_wait_time(max_wait_time), .max_burst_len(max_burst_len),
    .addr_dout(addr_dout), .addr_empty_n(addr_empty_n), .addr_read(addr_read),
    .burst_addr_din(burst_addr_din), .burst_addr_full_n(burst_addr_full_n),
    .burst_addr_write(burst_addr_write),
    .burst_len_0_din(burst_len_0_din), .burst_len_0_full_n(burst_len_0_full_n),
    .burst_len_0_write(burst_len_0_write),
    .burst_len_1_din(burst_len_1_din), .burst_len_1_full_n(burst_len_1_full_n),
    .burst_len_1_write(burst_len_1_write)
`ifdef BURST_COALESCER_STATS_EN
    , .stat_bursts(stat_bursts), .stat_beats(stat_beats), .stat_timeouts(stat_timeouts)
`endif
  );

  // ---------------------------------------------------------------- bench state
  logic [AW-1:0] q0[$];
  logic [AW-1:0] q1[$];
  logic [BW-1:0] exp_q[$];
  logic [NCH-1:0] pend_read = '0;
  bit   rand_ready = 1'b0;
  bit   fix_a = 1'b1, fix_l0 = 1'b1, fix_l1 = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pop_cyc = -1;
  int   last_push_cyc = -1;
  int   model_ptr = 0;
  logic [BW-1:0] mon_e;

  function automatic logic [AW-1:0] al(input logic [AW-1:0] a);
    return a & ~64'h3F;
  endfunction

  // ------------------------------------------------ FIFO / downstream driver
  always @(posedge clk) begin
    #1;
    if (pend_read[0] && q0.size() > 0) void'(q0.pop_front());
    if (pend_read[1] && q1.size() > 0) void'(q1.pop_front());
    if (rand_ready) begin
      burst_addr_full_n  = ($urandom_range(0, 3) != 0);
      burst_len_0_full_n = ($urandom_range(0, 3) != 0);
      burst_len_1_full_n = ($urandom_range(0, 3) != 0);
    end else begin
      burst_addr_full_n  = fix_a;
      burst_len_0_full_n = fix_l0;
      burst_len_1_full_n = fix_l1;
    end
    addr_empty_n[0]      = (q0.size() > 0);
    addr_empty_n[1]      = (q1.size() > 0);
    addr_dout[AW-1:0]    = (q0.size() > 0) ? q0[0] : '0;
    addr_dout[2*AW-1:AW] = (q1.size() > 0) ? q1[0] : '0;
  end

  // ------------------------------------------------------------ monitor
  always @(negedge clk) begin
    cyc++;
    pend_read = addr_read;
    if (addr_read != '0) begin
      last_pop_cyc = cyc;
      checks++;
      if (!$onehot(addr_read) || ((addr_read & ~addr_empty_n) != '0)) begin
        errors++;
        $display("FAIL addr_read got %b with valid %b", addr_read, addr_empty_n);
      end
    end
    if (burst_addr_write || burst_len_0_write || burst_len_1_write) begin
      last_push_cyc = cyc;
      checks++;
      if (!(burst_addr_write && burst_len_0_write && burst_len_1_write)) begin
        errors++;
        $display("FAIL push_atomic got writes %b%b%b required 111",
                 burst_addr_write, burst_len_0_write, burst_len_1_write);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push got %h required none", burst_addr_din);
      end else begin
        mon_e = exp_q.pop_front();
        if (burst_addr_din != mon_e || burst_len_0_din != mon_e[BW-1:AW] ||
            burst_len_1_din != mon_e[BW-1:AW]) begin
          errors++;
          $display("FAIL burst got %h len0 %h len1 %h required %h",
                   burst_addr_din, burst_len_0_din, burst_len_1_din, mon_e);
        end
      end
    end
  end

  // ------------------------------------------ burst-level reference model
  // Queues are fully loaded before the DUT sees them, so a burst only stops
  // for the limit, the boundary, a break in contiguity or an empty channel.
  task automatic run_model();
    logic [AW-1:0] m0[$];
    logic [AW-1:0] m1[$];
    m0 = q0;
    m1 = q1;
    while (m0.size() + m1.size() > 0) begin
      int ch;
      int len;
      logic [AW-1:0] base;
      logic [AW-1:0] nxt;
      if (model_ptr == 0) ch = (m0.size() > 0) ? 0 : 1;
      else                ch = (m1.size() > 0) ? 1 : 0;
      if (ch == 0) base = al(m0.pop_front());
      else         base = al(m1.pop_front());
      len = 0;
      forever begin
        nxt = base + 64'((len + 1) * 64);
        if (len == int'(max_burst_len) || (nxt % 4096) == 0) break;
        if (ch == 0 && m0.size() > 0 && al(m0[0]) == nxt) begin
          void'(m0.pop_front()); len++;
        end else if (ch == 1 && m1.size() > 0 && al(m1[0]) == nxt) begin
          void'(m1.pop_front()); len++;
        end else begin
          break;
        end
      end
      exp_q.push_back({1'(ch), 8'(len), base});
      model_ptr = (ch + 1) % NCH;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0) break;
      step(1);
    end
    checks++;
    if (i >= 3000) begin
      errors++;
      $display("FAIL drain_%s got pending exp %0d q0 %0d q1 %0d required 0",
               name, exp_q.size(), q0.size(), q1.size());
      exp_q.delete(); q0.delete(); q1.delete();
    end
    step(3);
  endtask

  task automatic gen_chan(input int ch, input int n);
    logic [AW-1:0] a;
    logic [AW-1:0] w;
    a = {$urandom, $urandom};
    if ($urandom_range(0, 2) == 0) a = {a[63:12], 12'h0} - 64'(64 * $urandom_range(1, 4));
    for (int k = 0; k < n; k++) begin
      w = al(a) | 64'($urandom_range(0, 63));
      if (ch == 0) q0.push_back(w); else q1.push_back(w);
      case ($urandom_range(0, 9))
        8:       a = al(a) + 64'd128;
        9:       a = {$urandom, $urandom};
        default: a = al(a) + 64'd64;
      endcase
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    #2 rst_n = 1'b0;
    max_wait_time = 4'd2;
    max_burst_len = 8'd255;
    step(3);
    @(negedge clk); #1;
    checks++;
    if (addr_read != '0 || burst_addr_write || burst_len_0_write || burst_len_1_write) begin
      errors++;
      $display("FAIL reset_outputs got read %b writes %b%b%b required 0", addr_read,
               burst_addr_write, burst_len_0_write, burst_len_1_write);
    end
    step(1);
    rst_n = 1'b1;
    step(2);

    // Contiguous run merged into one burst.
    q0.push_back(64'h0); q0.push_back(64'h40); q0.push_back(64'h80); q0.push_back(64'hC0);
    run_model();
    drain("contig");

    // 4 KiB boundary split.
    q0.push_back(64'hF80); q0.push_back(64'hFC0); q0.push_back(64'h1000);
    run_model();
    drain("boundary");

    // Length limit split on channel 1.
    max_burst_len = 8'd3;
    for (int k = 0; k < 8; k++) q1.push_back(64'(k * 64));
    run_model();
    drain("maxlen");

    // Both channels valid together, lone words.
    max_burst_len = 8'd255;
    max_wait_time = 4'd0;
    q0.push_back(64'h0); q1.push_back(64'h1000);
    run_model();
    drain("rr");

    // Lone address: push two cycles after its pop.
    q0.push_back(64'h9000);
    run_model();
    drain("latency");
    checks++;
    if (last_push_cyc - last_pop_cyc != 2) begin
      errors++;
      $display("FAIL latency got %0d required 2", last_push_cyc - last_pop_cyc);
    end

    // Backpressure on one bookkeeping FIFO holds the whole push.
    fix_l1 = 1'b0;
    q0.push_back(64'h7000);
    run_model();
    step(3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++;
      if (burst_addr_write || burst_len_0_write || burst_len_1_write ||
          exp_q.size() != 1 || burst_addr_din != exp_q[0]) begin
        errors++;
        $display("FAIL hold got writes %b%b%b din %h required 000 din %h",
                 burst_addr_write, burst_len_0_write, burst_len_1_write, burst_addr_din,
                 (exp_q.size() > 0) ? exp_q[0] : '0);
      end
    end
    fix_l1 = 1'b1;
    drain("hold");

    // Reset in the middle of ACCUM drops the burst and the pointer.
    max_wait_time = 4'd15;
    q1.push_back(64'h0);
    for (int k = 0; k < 20 && q1.size() > 0; k++) step(1);
    step(3);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (addr_read != '0 || burst_addr_write || burst_len_0_write || burst_len_1_write) begin
      errors++;
      $display("FAIL reset_mid got read %b writes %b%b%b required 0", addr_read,
               burst_addr_write, burst_len_0_write, burst_len_1_write);
    end
    max_wait_time = 4'd0;
    q0.push_back(64'h100); q1.push_back(64'h3000);
    step(2);
    @(negedge clk); #1;
    checks++;
    if (addr_read != '0 || burst_addr_write) begin
      errors++;
      $display("FAIL reset_hold got read %b write %b required 0", addr_read, burst_addr_write);
    end
    step(1);
    model_ptr = 0;
    run_model();
    rst_n = 1'b1;
    drain("after_reset");

    // Randomized batches with random downstream readiness.
    rand_ready = 1'b1;
    for (int b = 0; b < 25; b++) begin
      max_wait_time = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       max_burst_len = 8'd0;
        1:       max_burst_len = 8'($urandom_range(1, 4));
        2:       max_burst_len = 8'd15;
        default: max_burst_len = 8'd255;
      endcase
      gen_chan(0, $urandom_range(0, 12));
      gen_chan(1, $urandom_range(0, 12));
      run_model();
      drain("random");
    end
    rand_ready = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/burst_coalescer.md
Name: burst_coalescer

Overview:
Multi-channel successor to the single-stream burst detector in the memory-mapped AXI adapter. It takes NumChannels streams of individual beat addresses and round-robin arbitrates between them. Contiguous addresses from one channel are merged into an AXI INCR burst, and each burst is tagged with the source channel as its AXI ID. Bursts are split at the 4 KiB boundary, at max_burst_len and on a wait-time timeout. The block sits between the per-channel address FIFOs and the AW/AR relay stations and the W-last/B-response bookkeeping FIFOs.

Parameters:
AddrWidth, 64, byte-address width
DataWidthBytesLog, 6, log2 of bytes per beat; address step = 1<<DataWidthBytesLog
WaitTimeWidth, 4, width of max_wait_time and the idle counter
BurstLenWidth, 8, AXI LEN width (beats-1 encoding)
NumChannels, 2, number of input address channels (>=1)
ChanIdWidth, 1, ID width; must satisfy 2**ChanIdWidth >= NumChannels
BoundaryLog, 12, log2 of the no-cross boundary in bytes

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
max_wait_time  in  WaitTimeWidth  idle cycles tolerated before closing a burst
max_burst_len  in  BurstLenWidth  max LEN (beats-1)
addr_dout  in  NumChannels*AddrWidth  packed per-channel addresses, channel 0 in LSBs
addr_empty_n  in  NumChannels  per-channel valid
addr_read  out  NumChannels  per-channel pop, at most one bit set
burst_addr_din  out  ChanIdWidth+BurstLenWidth+AddrWidth  {id, len, addr}
burst_addr_full_n  in  1  downstream ready
burst_addr_write  out  1  push
burst_len_0_din / burst_len_1_din  out  ChanIdWidth+BurstLenWidth each  {id, len}, for the W-last generator and the B-response tracker
burst_len_0_full_n / burst_len_1_full_n  in  1 each
burst_len_0_write / burst_len_1_write  out  1 each

Behaviour:
- Reset (async, rst_n=0): state IDLE, rr pointer 0, len 0, wait_cnt 0. All addr_read and *_write outputs are 0. Any partially accumulated burst is dropped, including addresses already popped.
- States: IDLE, ACCUM, EMIT.
- IDLE:
  - Grant the first channel with addr_empty_n=1 at or after the rr pointer, wrapping.
  - Pop it the same cycle: addr_read[g]=1.
  - Latch base = addr with low DataWidthBytesLog bits zeroed, cur_id=g, len=0, wait_cnt=0.
  - Go to ACCUM. If no channel is valid, stay in IDLE.
- ACCUM: a word is accepted when addr_empty_n[cur_id]=1 AND aligned addr == next_addr (base + (len+1)<<DataWidthBytesLog). Evaluate in this order:
  1. If len == max_burst_len, or next_addr[BoundaryLog-1:0]==0: go to EMIT without looking at input.
  2. Else if a word is accepted: pop it, len++, wait_cnt=0.
  3. Else if addr_empty_n[cur_id]=1 with a non-contiguous address: go to EMIT; the word is not popped.
  4. Else if wait_cnt == max_wait_time: go to EMIT.
  5. Else wait_cnt++.
- Simultaneous events: a word accepted in the same cycle wait_cnt reaches the limit wins over the timeout. Other channels' addr_empty_n is ignored while in ACCUM.
- EMIT:
  - All three writes are asserted together, and only when burst_addr_full_n & burst_len_0_full_n & burst_len_1_full_n (atomic push). Otherwise hold.
  - On push: rr pointer = cur_id+1 (mod NumChannels), go to IDLE.
  - Outputs are valid and stable throughout EMIT.
- max_burst_len=0 gives single-beat bursts. Minimum turnaround is 3 cycles per burst (IDLE, ACCUM, EMIT).
- Latency: a lone address popped at cycle t, with max_wait_time=0, is pushed at t+2 when downstream is ready.
- Width: len saturates at max_burst_len and never wraps. next_addr wraps modulo 2**AddrWidth.

Optional Feature:
BURST_COALESCER_STATS_EN.
- Defined: adds outputs stat_bursts[31:0], stat_beats[31:0] and stat_timeouts[31:0], each wrapping and cleared by rst_n.
  - stat_bursts increments on each push.
  - stat_beats adds len+1 on each push.
  - stat_timeouts increments on ACCUM->EMIT via rule 4.
- Undefined: the ports and counters are absent; the core behaviour is identical.

Decomposition:
- Package burst_coalescer_pkg holds:
  - state encoding localparams S_IDLE/S_ACCUM/S_EMIT;
  - AXI_LEN_WIDTH=8;
  - DEFAULT_BOUNDARY_LOG=12;
  - a function returning the aligned address.
- One sub-module, rr_arbiter (NumChannels; inputs req, ptr; output one-hot grant and index).

Test Plan:
- Ch0 pushes 0x0,0x40,0x80,0xC0 back-to-back; max_wait_time=2, max_burst_len=255 -> one push {id0, len 3, addr 0x0}.
- Ch0 pushes 0xF80, 0xFC0, 0x1000 -> two pushes: {0,1,0xF80} then {0,0,0x1000} (boundary split).
- max_burst_len=3; ch1 streams 0x0..0x1C0 (8 beats) -> {1,3,0x0} then {1,3,0x100}.
- Both channels hold valid at the same time: ch0 gets 0x0, ch1 gets 0x1000; lone words; max_wait_time=0 -> ch0 burst first, then ch1; the rr pointer alternates thereafter.
- Hold burst_len_1_full_n=0 during EMIT for 5 cycles -> no write on any output, din stable; release -> exactly one simultaneous push.
- Assert rst_n low mid-ACCUM -> all writes and reads drop immediately; after release, IDLE and rr pointer 0.
